// File: rtl/sprite_path_sequencer.sv
// Table-driven sprite animation engine: plays a host-loaded keyframe table on
// animation ticks and drives sprite position, frame and key index to the renderer.
module sprite_path_sequencer #(
   parameter int CW = 10,
   parameter int FW = 5,
   parameter int NK = 16,
   parameter int HW = 4,
   parameter int DW = 6,
   localparam int KW = $clog2(NK)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Tick,
   input  logic          Start,
   input  logic          Abort,
   input  logic          Loop,
   input  logic          Wr_En,
   input  logic [KW-1:0] Wr_Addr,
   input  logic [CW-1:0] Wr_X,
   input  logic [CW-1:0] Wr_Y,
   input  logic [DW-1:0] Wr_DX,
   input  logic [DW-1:0] Wr_DY,
   input  logic [FW-1:0] Wr_Frame,
   input  logic [HW-1:0] Wr_Hold,
   input  logic          Wr_Last,
   output logic [CW-1:0] Sprite_X,
   output logic [CW-1:0] Sprite_Y,
   output logic [FW-1:0] Frame,
   output logic [KW-1:0] Key_Idx,
   output logic          Busy,
   output logic          Done
);

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [DW-1:0] dx;
      logic [DW-1:0] dy;
      logic [FW-1:0] frame;
      logic [HW-1:0] hold;
      logic          last;
   } key_t;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

   state_t        state_q;
   key_t          table_q [NK];
   logic [CW-1:0] x_q, y_q;
   logic [FW-1:0] frame_q;
   logic [KW-1:0] key_q;
   logic [HW-1:0] hold_q;
   logic          loop_q, busy_q, done_q;

   key_t          curKey, nextKey, firstKey;
   logic [CW-1:0] stepX_d, stepY_d;
   logic          isLast;

   // Table is frozen during playback so a running sequence never sees a half-updated key.
   always_ff @(posedge Clk) begin
      if (Wr_En && !busy_q) begin
         table_q[Wr_Addr] <= '{x: Wr_X, y: Wr_Y, dx: Wr_DX, dy: Wr_DY,
                               frame: Wr_Frame, hold: Wr_Hold, last: Wr_Last};
      end
   end

   always_comb begin
      curKey   = table_q[key_q];
      nextKey  = table_q[key_q + KW'(1)];
      firstKey = table_q[KW'(0)];
      stepX_d  = x_q + CW'($signed(curKey.dx));
      stepY_d  = y_q + CW'($signed(curKey.dy));
      isLast   = curKey.last || (key_q == KW'(NK - 1));
   end

   // Abort beats Start beats Tick; a Tick coinciding with Start is absorbed by the load.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         frame_q <= '0;
         key_q   <= '0;
         hold_q  <= '0;
         loop_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (Abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (Start) begin
                     state_q <= S_PLAY;
                     busy_q  <= 1'b1;
                     loop_q  <= Loop;
                     key_q   <= '0;
                     x_q     <= firstKey.x;
                     y_q     <= firstKey.y;
                     frame_q <= firstKey.frame;
                     hold_q  <= firstKey.hold;
                  end
               end
               S_PLAY: begin
                  if (Tick) begin
                     if (hold_q != '0) begin
                        x_q    <= stepX_d;
                        y_q    <= stepY_d;
                        hold_q <= hold_q - HW'(1);
                     end else if (!isLast) begin
                        key_q   <= key_q + KW'(1);
                        x_q     <= nextKey.x;
                        y_q     <= nextKey.y;
                        frame_q <= nextKey.frame;
                        hold_q  <= nextKey.hold;
                     end else if (loop_q) begin
                        key_q   <= '0;
                        x_q     <= firstKey.x;
                        y_q     <= firstKey.y;
                        frame_q <= firstKey.frame;
                        hold_q  <= firstKey.hold;
                     end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Sprite_X = x_q;
   assign Sprite_Y = y_q;
   assign Frame    = frame_q;
   assign Key_Idx  = key_q;
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_sprite_path_sequencer.sv
// Scoreboard bench for sprite_path_sequencer: a tick-count reference model pushes
// the expected outputs per edge and an independent monitor compares them.
module tb_sprite_path_sequencer;

   localparam int CW = 10;
   localparam int FW = 5;
   localparam int NK = 16;
   localparam int HW = 4;
   localparam int DW = 6;
   localparam int KW = 4;

   typedef struct {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [FW-1:0] f;
      logic [KW-1:0] k;
      logic          busy;
      logic          done;
   } exp_t;

   logic          Clk = 1'b0;
   logic          Reset, Tick, Start, Abort, Loop, Wr_En, Wr_Last;
   logic [KW-1:0] Wr_Addr;
   logic [CW-1:0] Wr_X, Wr_Y;
   logic [DW-1:0] Wr_DX, Wr_DY;
   logic [FW-1:0] Wr_Frame;
   logic [HW-1:0] Wr_Hold;
   logic [CW-1:0] Sprite_X, Sprite_Y;
   logic [FW-1:0] Frame;
   logic [KW-1:0] Key_Idx;
   logic          Busy, Done;

   exp_t expQ[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cycleNo = 0;

   // Reference model: position is key start plus ticks-in-key times delta.
   int   mX[NK], mY[NK], mDX[NK], mDY[NK], mF[NK], mH[NK];
   bit   mL[NK];
   bit   mPlaying, mInDone, mLoop;
   int   mKey, mT;
   logic [CW-1:0] oX, oY;
   logic [FW-1:0] oF;
   logic [KW-1:0] oK;
   logic          oBusy, oDone;

   sprite_path_sequencer #(.CW(CW), .FW(FW), .NK(NK), .HW(HW), .DW(DW)) dut (
      .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Abort(Abort), .Loop(Loop),
      .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_X(Wr_X), .Wr_Y(Wr_Y), .Wr_DX(Wr_DX),
      .Wr_DY(Wr_DY), .Wr_Frame(Wr_Frame), .Wr_Hold(Wr_Hold), .Wr_Last(Wr_Last),
      .Sprite_X(Sprite_X), .Sprite_Y(Sprite_Y), .Frame(Frame), .Key_Idx(Key_Idx),
      .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic modelReset();
      mPlaying = 0; mInDone = 0; mLoop = 0; mKey = 0; mT = 0;
      oX = '0; oY = '0; oF = '0; oK = '0; oBusy = 0; oDone = 0;
   endtask

   task automatic show();
      int sx, sy;
      logic [31:0] vx, vy;
      sx = mX[mKey] + mT * mDX[mKey];
      sy = mY[mKey] + mT * mDY[mKey];
      vx = sx;
      vy = sy;
      oX = vx[CW-1:0];
      oY = vy[CW-1:0];
      oF = FW'(mF[mKey]);
      oK = KW'(mKey);
   endtask

   task automatic modelStep();
      bit wrOk;
      int a;
      wrOk  = Wr_En && !mPlaying;
      oDone = 0;
      if (Abort) begin
         mPlaying = 0;
         mInDone  = 0;
      end else if (mInDone) begin
         mInDone = 0;
      end else if (!mPlaying) begin
         if (Start) begin
            mPlaying = 1; mKey = 0; mT = 0; mLoop = Loop;
            show();
         end
      end else if (Tick) begin
         if (mT < mH[mKey]) begin
            mT++;
            show();
         end else if (!(mL[mKey] || mKey == NK - 1)) begin
            mKey++; mT = 0;
            show();
         end else if (mLoop) begin
            mKey = 0; mT = 0;
            show();
         end else begin
            mPlaying = 0; mInDone = 1; oDone = 1;
         end
      end
      oBusy = mPlaying;
      if (wrOk) begin
         a = int'(Wr_Addr);
         mX[a]  = int'(Wr_X);
         mY[a]  = int'(Wr_Y);
         mDX[a] = int'($signed(Wr_DX));
         mDY[a] = int'($signed(Wr_DY));
         mF[a]  = int'(Wr_Frame);
         mH[a]  = int'(Wr_Hold);
         mL[a]  = Wr_Last;
      end
   endtask

   task automatic pushExpected();
      exp_t e;
      e.x = oX; e.y = oY; e.f = oF; e.k = oK; e.busy = oBusy; e.done = oDone;
      expQ.push_back(e);
   endtask

   task automatic clearStrobes();
      Start = 0; Tick = 0; Abort = 0; Wr_En = 0;
   endtask

   task automatic applyStimulus();
      @(posedge Clk);
      #1;
      modelStep();
      pushExpected();
      @(negedge Clk);
      clearStrobes();
   endtask

   task automatic checkOutput(input exp_t e);
      compared++;
      if (Sprite_X !== e.x || Sprite_Y !== e.y || Frame !== e.f || Key_Idx !== e.k ||
          Busy !== e.busy || Done !== e.done) begin
         mismatched++;
         $display("[TB] FAIL outputs@cyc%0d: got X=%0d Y=%0d F=%0d K=%0d Busy=%0b Done=%0b, want X=%0d Y=%0d F=%0d K=%0d Busy=%0b Done=%0b",
                  cycleNo, Sprite_X, Sprite_Y, Frame, Key_Idx, Busy, Done,
                  e.x, e.y, e.f, e.k, e.busy, e.done);
      end
   endtask

   // Monitor: every pushed expectation is compared on the falling edge after it.
   always @(negedge Clk) begin
      cycleNo++;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   task automatic cyc(input bit st, input bit tk, input bit ab, input bit lp);
      Start = st; Tick = tk; Abort = ab; Loop = lp;
      applyStimulus();
   endtask

   task automatic writeKey(input int a, input int x, input int y, input int dx, input int dy,
                           input int f, input int h, input bit l);
      Wr_En = 1; Wr_Addr = KW'(a); Wr_X = CW'(x); Wr_Y = CW'(y);
      Wr_DX = DW'(dx); Wr_DY = DW'(dy); Wr_Frame = FW'(f); Wr_Hold = HW'(h); Wr_Last = l;
      applyStimulus();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(0, 1, 0, 0);
         cyc(0, 0, 0, 0);
      end
   endtask

   task automatic loadDogTable();
      writeKey(0, 11, 300, 8, 0, 1, 3, 0);
      writeKey(1, 43, 300, 0, 0, 4, 1, 0);
      writeKey(2, 267, 300, 9, -16, 7, 0, 1);
   endtask

   initial begin
      Reset = 0; Loop = 0; Wr_Addr = '0; Wr_X = '0; Wr_Y = '0; Wr_DX = '0; Wr_DY = '0;
      Wr_Frame = '0; Wr_Hold = '0; Wr_Last = 0;
      clearStrobes();
      for (int i = 0; i < NK; i++) begin
         mX[i] = 0; mY[i] = 0; mDX[i] = 0; mDY[i] = 0; mF[i] = 0; mH[i] = 0; mL[i] = 0;
      end
      modelReset();
      #1;
      pushExpected();
      @(negedge Clk);
      Reset = 1;

      // One-shot walk, then Start arriving during the Done cycle.
      loadDogTable();
      cyc(1, 0, 0, 0);
      ticks(6);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // Looped playback with a Start while busy, ended by Abort.
      cyc(1, 0, 0, 1);
      ticks(3);
      cyc(1, 0, 0, 0);
      ticks(4);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);

      // Abort after two ticks, then restart.
      cyc(1, 0, 0, 0);
      ticks(2);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      ticks(1);
      cyc(0, 0, 1, 0);

      // Collisions: Start+Tick, write while busy, Abort+Start.
      cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0);
      writeKey(0, 500, 100, -5, 3, 9, 2, 1);
      ticks(2);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      ticks(2);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 1, 0);
      cyc(0, 1, 0, 0);

      // Coordinate wrap-around.
      writeKey(0, 1020, 5, 8, -8, 2, 1, 1);
      cyc(1, 0, 0, 0);
      ticks(3);

      // Asynchronous reset mid-play, then replay.
      loadDogTable();
      cyc(1, 0, 0, 0);
      ticks(2);
      #2;
      Reset = 0;
      modelReset();
      pushExpected();
      @(negedge Clk);
      Reset = 1;
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      ticks(2);

      // Randomised phase: fresh full table, then random strobes.
      cyc(0, 0, 1, 0);
      for (int i = 0; i < NK; i++)
         writeKey(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                  $urandom_range(0, 31), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      for (int n = 0; n < 1500; n++) begin
         Wr_En    = ($urandom_range(0, 15) == 0);
         Wr_Addr  = KW'($urandom_range(0, NK - 1));
         Wr_X     = CW'($urandom_range(0, 1023));
         Wr_Y     = CW'($urandom_range(0, 1023));
         Wr_DX    = DW'($urandom_range(0, 63));
         Wr_DY    = DW'($urandom_range(0, 63));
         Wr_Frame = FW'($urandom_range(0, 31));
         Wr_Hold  = HW'($urandom_range(0, 3));
         Wr_Last  = ($urandom_range(0, 3) == 0);
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge Clk);
      #1;
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
